// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared encodings and helpers for the dm_be data memory.
//            Access-size codes, the clear/run state type and byte-lane
//            helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Lane-enable mask for a store; the reserved size code behaves as a word.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Natural-alignment check; the reserved size code is checked as a word.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return |off;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_be_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_be_if
// Purpose  : MEM-stage access bus between the pipeline (master) and the
//            byte-enabled data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dm_be_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        busy;
  logic        adel;
  logic        ades;

  modport master (
    output addr, wdata, we, re, size, ld_unsigned, pc,
    input  rdata, busy, adel, ades
  );

  modport slave (
    input  addr, wdata, we, re, size, ld_unsigned, pc,
    output rdata, busy, adel, ades
  );

endinterface
`default_nettype wire

// File: rtl/dm_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : dm_load_ext
// Purpose  : Selects the addressed byte/halfword of a memory word and
//            sign- or zero-extends it to 32 bits. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [1:0]  size_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lanes: shifting down by the offset brings the lane to bit 0.
  assign w_byte = 8'(word_i >> {byte_off_i, 3'b000});
  assign w_half = 16'(word_i >> {byte_off_i[1], 4'b0000});

  // Size-dependent extension; word and reserved sizes pass through.
  always_comb begin
    rdata_o = word_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{~ld_unsigned_i & w_byte[7]}}, w_byte};
      SZ_HALF: rdata_o = {{16{~ld_unsigned_i & w_half[15]}}, w_half};
      default: rdata_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dm_be.sv
`default_nettype none
// ============================================================================
// Module   : dm_be
// Purpose  : Byte-addressable data memory for the MEM stage. Byte/half/word
//            stores via lane enables, extended loads, misalign and range
//            fault flags, and a post-reset sequential clear sweep that holds
//            busy high until every word has been zeroed.
//            Optional macro DM_TRACE_EN prints one line per committed store.
// Revision : 1.0 - initial release
// ============================================================================
module dm_be
  import dm_pkg::*;
#(
  parameter int DEPTH = 3072
) (
  input  logic   clk,
  input  logic   reset,
  dm_be_if.slave bus
);

  localparam int              AW          = $clog2(DEPTH);
  localparam logic [29:0]     c_depth_w   = 30'(DEPTH);
  localparam logic [AW-1:0]   c_last_idx  = AW'(DEPTH - 1);

  state_t        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          busy_q;
  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] w_widx;
  logic          w_in_range;
  logic          w_fault;
  logic          w_store;
  logic [3:0]    w_be;
  logic [31:0]   w_word;
  logic [31:0]   w_wpos;
  logic [31:0]   w_merged;
  logic [31:0]   w_ext;
  logic          w_unused_pc;

  // pc only feeds the optional store trace.
  assign w_unused_pc = ^bus.pc;

  assign w_widx     = bus.addr[AW+1:2];
  assign w_in_range = bus.addr[31:2] < c_depth_w;
  assign w_fault    = misaligned(bus.size, bus.addr[1:0]) | ~w_in_range;
  // Out-of-range indices never reach the array, so nothing aliases.
  assign w_word     = w_in_range ? mem_q[w_widx] : '0;
  assign w_be       = lane_enables(bus.size, bus.addr[1:0]);
  assign w_store    = (state_q == RUN) & bus.we & ~w_fault;

  // Replicate sub-word store data onto every lane it could occupy.
  always_comb begin
    w_wpos = bus.wdata;
    case (bus.size)
      SZ_BYTE: w_wpos = {4{bus.wdata[7:0]}};
      SZ_HALF: w_wpos = {2{bus.wdata[15:0]}};
      default: w_wpos = bus.wdata;
    endcase
  end

  // Per-lane merge: enabled lanes take new data, others keep the old word.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_merged[8*i +: 8] = w_be[i] ? w_wpos[8*i +: 8] : w_word[8*i +: 8];
  end

  dm_load_ext u_load_ext (
    .word_i        (w_word),
    .byte_off_i    (bus.addr[1:0]),
    .size_i        (bus.size),
    .ld_unsigned_i (bus.ld_unsigned),
    .rdata_o       (w_ext)
  );

  assign bus.rdata = (busy_q | w_fault) ? '0 : w_ext;
  assign bus.busy  = busy_q;
  assign bus.adel  = ~busy_q & bus.re & w_fault;
  assign bus.ades  = ~busy_q & bus.we & w_fault;

  // Clear-sweep FSM: walks every index once after reset, then idles in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == c_last_idx) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: state_q <= RUN;
        default: begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array write port: sweep zeroing while clearing, merged stores afterwards.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (w_store) begin
      mem_q[w_widx] <= w_merged;
`ifdef DM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, w_merged);
`else
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_be
// Purpose  : Directed self-checking bench for dm_be (DEPTH = 16). Expected
//            values are queued when stimulus is applied and popped when the
//            corresponding DUT output is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_be;
  import dm_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_next = 32'h0040_0000;

  always #5 clk = ~clk;

  dm_be_if bus();

  dm_be #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic push_exp(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd, input logic w, input logic r);
    bus.addr        = a;
    bus.size        = sz;
    bus.ld_unsigned = uns;
    bus.wdata       = wd;
    bus.we          = w;
    bus.re          = r;
    bus.pc          = pc_next;
    pc_next         = pc_next + 32'd4;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    drive(a, sz, 1'b0, wd, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic uns, input logic [31:0] e);
    drive(a, sz, uns, 32'h0, 1'b0, 1'b1);
    push_exp(e);
    #2;
    check(tag, bus.rdata);
    bus.re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    drive(32'h0, SZ_WORD, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    push_exp(32'd1);
    check("busy_in_reset", {31'b0, bus.busy});

    // First sweep: busy must fall on the DEPTH-th edge after release.
    reset = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    push_exp(32'd16);
    check("sweep_len", 32'(n));

    // Second sweep, restarted by a reset pulse after 5 edges.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    push_exp(32'd1);
    check("busy_mid_sweep", {31'b0, bus.busy});
    reset = 1'b1;
    #2;
    reset = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 11) begin
        // Store to an already-cleared word while busy: must be dropped.
        drive(32'h4, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
      end else if (n == 12) begin
        push_exp(32'h0);
        check("busy_rdata", bus.rdata);
        bus.addr = 32'h6;
        #1;
        push_exp(32'h0);
        check("busy_ades", {31'b0, bus.ades});
        push_exp(32'h0);
        check("busy_adel", {31'b0, bus.adel});
        bus.we = 1'b0;
        bus.re = 1'b0;
      end
    end
    push_exp(32'd16);
    check("sweep_len_restart", 32'(n));

    for (int i = 0; i < DEPTH; i++) begin
      load($sformatf("clear_rd[%0d]", i), 32'(4 * i), SZ_WORD, 1'b0, 32'h0);
    end

    // Lane merging.
    store(32'h8, 32'h1234_5678, SZ_WORD);
    store(32'hA, 32'h0000_BEEF, SZ_HALF);
    store(32'h8, 32'h0000_005A, SZ_BYTE);
    load("merge_word", 32'h8, SZ_WORD, 1'b0, 32'hBEEF_565A);

    // Load extension.
    store(32'h0, 32'h80FF_7F01, SZ_WORD);
    load("lb_2",  32'h2, SZ_BYTE, 1'b0, 32'hFFFF_FFFF);
    load("lbu_3", 32'h3, SZ_BYTE, 1'b1, 32'h0000_0080);
    load("lb_1",  32'h1, SZ_BYTE, 1'b0, 32'h0000_007F);
    load("lh_2",  32'h2, SZ_HALF, 1'b0, 32'hFFFF_80FF);
    load("lhu_0", 32'h0, SZ_HALF, 1'b1, 32'h0000_7F01);

    // Misaligned stores are flagged and suppressed.
    drive(32'h6, SZ_WORD, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    #1;
    push_exp(32'h1);
    check("ades_word_mis", {31'b0, bus.ades});
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    load("mis_word_nowrite", 32'h4, SZ_WORD, 1'b0, 32'h0);
    drive(32'h1, SZ_HALF, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0);
    #1;
    push_exp(32'h1);
    check("ades_half_mis", {31'b0, bus.ades});
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    load("mis_half_nowrite", 32'h0, SZ_WORD, 1'b0, 32'h80FF_7F01);
    drive(32'h2, SZ_WORD, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    push_exp(32'h1);
    check("adel_lw_mis", {31'b0, bus.adel});
    push_exp(32'h0);
    check("rdata_lw_mis", bus.rdata);
    bus.re = 1'b0;
    #1;
    push_exp(32'h0);
    check("adel_needs_re", {31'b0, bus.adel});

    // Out-of-range accesses: flagged, no write, no aliasing onto word 0.
    drive(32'(4 * DEPTH), SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b1);
    #1;
    push_exp(32'h1);
    check("ades_range", {31'b0, bus.ades});
    push_exp(32'h1);
    check("adel_range", {31'b0, bus.adel});
    push_exp(32'h0);
    check("rdata_range", bus.rdata);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    load("range_no_alias", 32'h0, SZ_WORD, 1'b0, 32'h80FF_7F01);

    // Highest in-range word.
    store(32'h3C, 32'hA5A5_0F0F, SZ_WORD);
    load("last_word", 32'h3C, SZ_WORD, 1'b0, 32'hA5A5_0F0F);

    // Same-cycle load and store: old value now, new value after the edge.
    drive(32'hC, SZ_WORD, 1'b0, 32'h1111_2222, 1'b1, 1'b1);
    #1;
    push_exp(32'h0);
    check("rw_same_old", bus.rdata);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    #1;
    push_exp(32'h1111_2222);
    check("rw_same_new", bus.rdata);
    bus.re = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
